// File: rtl/seg7_bcd_encoder_if.sv
// Handshake and result bundle between the value source, the seven-segment encoder and the display side.
interface seg7_bcd_encoder_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   hex_out;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, overflow, bcd_out, hex_out
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, overflow, bcd_out, hex_out
  );
endinterface

// File: rtl/seg7_bcd_encoder.sv
// Iterative double-dabble binary-to-BCD converter driving active-low {g,f,e,d,c,b,a} segment codes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
//
// state   | meaning
// IDLE    | in_ready high, waiting for in_valid
// CONVERT | one shift-add-3 iteration per clock, then one settle cycle with counter at 0
// DONE    | results loaded on entry, out_valid pulses for this one cycle
module seg7_bcd_encoder #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  seg7_bcd_encoder_if.slave   bus_if
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint           MAX_VAL = pow10(DIGITS) - 1;
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [7*DIGITS-1:0] HEX_ZERO = {DIGITS{7'b1000000}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0011000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] encode(input logic [4*DIGITS-1:0] b);
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    encode = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      encode[7*k +: 7] = seg_of(b[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && (b[4*k +: 4] == 4'd0);
      if (lead && (k > 0)) encode[7*k +: 7] = 7'b1111111;
`endif
    end
  endfunction

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;

  logic [4*DIGITS-1:0]   acc_add;
  logic                  in_over;

  assign in_over = ({{(64-WIDTH){1'b0}}, bus_if.in_data} > 64'(MAX_VAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      bcd_q       <= '0;
      hex_q       <= HEX_ZERO;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      bcd_q       <= bcd_d;
      hex_q       <= hex_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    bcd_d       = bcd_q;
    hex_d       = hex_q;

    acc_add = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) acc_add[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        if (bus_if.in_valid) begin
          shift_d    = in_over ? MAX_W : bus_if.in_data;
          ovf_pend_d = in_over;
          acc_d      = '0;
          cnt_d      = CW'(WIDTH);
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (cnt_q == '0) begin
          // Results land atomically together with the out_valid pulse.
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          bcd_d       = acc_q;
          hex_d       = encode(acc_q);
          overflow_d  = ovf_pend_q;
        end else begin
          {acc_d, shift_d} = {acc_add, shift_q} << 1;
          cnt_d            = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_if.in_ready  = (state_q == S_IDLE) && !reset;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.overflow  = overflow_q;
  assign bus_if.bcd_out   = bcd_q;
  assign bus_if.hex_out   = hex_q;

endmodule
